derrida_histogram_collector: RTL

Consumer end of the Hamming-distance stream produced by the 3-bit XOR bit counter. It accumulates one counter per distance value over a run. At end-of-stream it drains the histogram bin by bin over a valid/ready handshake to the plotting/readout side. Together with the data producer and the distance counter it closes the Derrida measurement loop.

---
 rtl/derrida_histogram_collector_pkg.sv | 18 +
 rtl/derrida_histogram_collector_bin.sv | 33 +++
 rtl/derrida_histogram_collector.sv | 117 +++++++++++
 3 files changed

// File: rtl/derrida_histogram_collector_pkg.sv
// Shared definitions for the Derrida histogram collector: FSM encoding,
// default widths and the bin-count derivation.
package derrida_histogram_collector_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_FINISHED = 2'd2
  } state_t;

  localparam int DEF_DIST_WIDTH  = 2;
  localparam int DEF_COUNT_WIDTH = 16;

  function automatic int nbins_of(input int dist_width);
    return 1 << dist_width;
  endfunction

endpackage

// File: rtl/derrida_histogram_collector_bin.sv
// One saturating histogram bin: counts increments, holds at all-ones and
// flags an increment that arrived while saturated.
module hist_bin_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   clr,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [COUNT_WIDTH-1:0] next_count,
  output logic                   sat_hit
);

  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = '1;

  always_comb begin
    next_count = count;
    sat_hit    = 1'b0;
    if (clr) begin
      next_count = '0;
    end else if (inc) begin
      if (count == MAX_COUNT) sat_hit = 1'b1;
      else next_count = count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else      count <= next_count;
  end

endmodule

// File: rtl/derrida_histogram_collector.sv
// Histogram of Hamming distances: counts per distance while collecting, then
// drains every bin over a valid/ready port and waits for clear.
module derrida_histogram_collector
  import derrida_histogram_collector_pkg::*;
#(
  parameter int DIST_WIDTH  = DEF_DIST_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_data_valid,
  input  logic [DIST_WIDTH-1:0]  input_data,
  input  logic                   input_done,
  input  logic                   clear,
  input  logic                   output_ready,
  output logic                   output_data_valid,
  output logic [DIST_WIDTH-1:0]  output_bin,
  output logic [COUNT_WIDTH-1:0] output_data,
  output logic                   overflow,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  localparam int NBINS = nbins_of(DIST_WIDTH);
  localparam logic [DIST_WIDTH-1:0] LAST_BIN = DIST_WIDTH'(NBINS - 1);

  state_t state_q, state_d;
  logic                   valid_d, done_d, ovf_d, clr_bins;
  logic [DIST_WIDTH-1:0]  bin_d;
  logic [COUNT_WIDTH-1:0] data_d;
  logic [NBINS-1:0]       inc, sat_hit;
  logic [COUNT_WIDTH-1:0] counts     [NBINS];
  logic [COUNT_WIDTH-1:0] next_counts[NBINS];

  for (genvar g = 0; g < NBINS; g++) begin : g_bin
    hist_bin_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_bin (
      .clk        (clk),
      .rst        (rst),
      .inc        (inc[g]),
      .clr        (clr_bins),
      .count      (counts[g]),
      .next_count (next_counts[g]),
      .sat_hit    (sat_hit[g])
    );
  end

  // Output handshake: a bin moves when output_data_valid & output_ready at a
  // rising edge; while valid is high and ready low, bin and data hold.
  always_comb begin
    state_d  = state_q;
    valid_d  = output_data_valid;
    bin_d    = output_bin;
    data_d   = output_data;
    done_d   = done;
    ovf_d    = overflow;
    inc      = '0;
    clr_bins = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        for (int i = 0; i < NBINS; i++)
          inc[i] = input_data_valid && (input_data == DIST_WIDTH'(i));
        ovf_d = overflow | (|sat_hit);
        if (input_done) begin
          // next_counts so a sample coincident with input_done reaches bin 0
          state_d = ST_DRAIN;
          valid_d = 1'b1;
          bin_d   = '0;
          data_d  = next_counts[0];
        end
      end
      ST_DRAIN: begin
        if (output_data_valid && output_ready) begin
          if (output_bin == LAST_BIN) begin
            state_d = ST_FINISHED;
            valid_d = 1'b0;
            bin_d   = '0;
            data_d  = '0;
            done_d  = 1'b1;
          end else begin
            bin_d  = output_bin + DIST_WIDTH'(1);
            data_d = counts[output_bin + DIST_WIDTH'(1)];
          end
        end
      end
      ST_FINISHED: begin
        if (clear) begin
          state_d  = ST_COLLECT;
          clr_bins = 1'b1;
          ovf_d    = 1'b0;
          done_d   = 1'b0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= ST_COLLECT;
      output_data_valid <= 1'b0;
      output_bin        <= '0;
      output_data       <= '0;
      overflow          <= 1'b0;
      done              <= 1'b0;
    end else begin
      state_q           <= state_d;
      output_data_valid <= valid_d;
      output_bin        <= bin_d;
      output_data       <= data_d;
      overflow          <= ovf_d;
      done              <= done_d;
    end
  end

  assign dbg_state = state_q;

endmodule
